// File: rtl/delay_mem_arbiter_if.sv
// delay_mem_arbiter_if: client and memory-controller signal bundle for the shared delay-line memory arbiter
interface delay_mem_arbiter_if #(
  parameter int N_CLIENTS = 2,
  parameter int data_width = 16,
  parameter int memory_size = 8192
);
  localparam int addr_width = $clog2(memory_size);
  logic [N_CLIENTS-1:0] cli_read_req;
  logic [N_CLIENTS-1:0] cli_write_req;
  logic [N_CLIENTS*addr_width-1:0] cli_read_addr;
  logic [N_CLIENTS*addr_width-1:0] cli_write_addr;
  logic [N_CLIENTS*data_width-1:0] cli_write_data;
  logic [data_width-1:0] cli_read_data;
  logic [N_CLIENTS-1:0] cli_read_valid;
  logic [N_CLIENTS-1:0] cli_write_ack;
  logic mem_read_req;
  logic mem_write_req;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_data_out;
  logic [data_width-1:0] mem_data_in;
  logic mem_read_valid;
  logic mem_write_ack;
  logic timeout_err;
  modport slave (
    input cli_read_req, cli_write_req, cli_read_addr, cli_write_addr, cli_write_data,
    input mem_data_in, mem_read_valid, mem_write_ack,
    output cli_read_data, cli_read_valid, cli_write_ack,
    output mem_read_req, mem_write_req, mem_addr, mem_data_out, timeout_err
  );
  modport master (
    output cli_read_req, cli_write_req, cli_read_addr, cli_write_addr, cli_write_data,
    output mem_data_in, mem_read_valid, mem_write_ack,
    input cli_read_data, cli_read_valid, cli_write_ack,
    input mem_read_req, mem_write_req, mem_addr, mem_data_out, timeout_err
  );
endinterface

// File: rtl/delay_mem_arbiter.sv
// delay_mem_arbiter: round-robin arbiter sharing one delay-line memory port among clients, with a response watchdog
module delay_mem_arbiter #(
  parameter int N_CLIENTS = 2,
  parameter int data_width = 16,
  parameter int memory_size = 8192,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  delay_mem_arbiter_if.slave bus
);
  localparam int addr_width = $clog2(memory_size);
  localparam int iw = $clog2(N_CLIENTS);
  localparam int ww = $clog2(TIMEOUT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0] state;
  logic [iw-1:0] rr;
  logic [iw-1:0] g;
  logic [iw-1:0] gnt;
  logic [iw-1:0] cand;
  logic is_wr;
  logic found;
  logic done;
  logic sel_wr;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_data;
  logic [N_CLIENTS-1:0] holdoff;
  logic [N_CLIENTS-1:0] elig;
  logic [ww-1:0] wd;
  int j;
  assign elig = (bus.cli_read_req | bus.cli_write_req) & ~holdoff;
  assign done = is_wr ? bus.mem_write_ack : bus.mem_read_valid;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    cand = '0;
    j = 0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      j = j >= N_CLIENTS ? j - N_CLIENTS : j;
      cand = iw'(j);
      if (elig[cand]) begin
        found = 1'b1;
        gnt = cand;
      end
    end
  end
  always_comb begin
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt == iw'(i)) begin
        sel_wr = bus.cli_write_req[i];
        sel_addr = sel_wr ? bus.cli_write_addr[i*addr_width +: addr_width] : bus.cli_read_addr[i*addr_width +: addr_width];
        sel_data = bus.cli_write_data[i*data_width +: data_width];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      g <= '0;
      is_wr <= 1'b0;
      holdoff <= '0;
      wd <= '0;
      bus.cli_read_data <= '0;
      bus.cli_read_valid <= '0;
      bus.cli_write_ack <= '0;
      bus.mem_read_req <= 1'b0;
      bus.mem_write_req <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data_out <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.cli_read_valid <= '0;
      bus.cli_write_ack <= '0;
      bus.timeout_err <= 1'b0;
      if (state == IDLE) begin
        holdoff <= '0;
        if (found) begin
          g <= gnt;
          is_wr <= sel_wr;
          rr <= gnt == iw'(N_CLIENTS - 1) ? '0 : gnt + 1'b1;
          bus.mem_addr <= sel_addr;
          if (sel_wr) bus.mem_data_out <= sel_data;
          bus.mem_write_req <= sel_wr;
          bus.mem_read_req <= ~sel_wr;
          wd <= ww'(TIMEOUT);
          state <= WAIT;
        end
      end else if (done || wd == '0) begin
        bus.mem_write_req <= 1'b0;
        bus.mem_read_req <= 1'b0;
        holdoff[g] <= 1'b1;
        bus.timeout_err <= ~done;
        state <= IDLE;
        if (is_wr) bus.cli_write_ack[g] <= 1'b1;
        else begin
          bus.cli_read_valid[g] <= 1'b1;
          bus.cli_read_data <= done ? bus.mem_data_in : '0;
        end
      end else wd <= wd - 1'b1;
    end
  end
endmodule

// File: tb/tb_delay_mem_arbiter.sv
// tb_delay_mem_arbiter: directed self-checking bench for delay_mem_arbiter
module tb_delay_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  delay_mem_arbiter_if #(.N_CLIENTS(2), .data_width(DW), .memory_size(8192)) bus ();
  delay_mem_arbiter #(.N_CLIENTS(2), .data_width(DW), .memory_size(8192), .TIMEOUT(255)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.mem_read_req, bus.mem_write_req, bus.timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {bus.mem_read_req, bus.mem_write_req, bus.timeout_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_data_out);
    end
    checks++;
    if ({bus.cli_read_valid, bus.cli_write_ack, bus.cli_read_data} !== '0) begin
      failures++;
      $display("FAIL reset_cli got=%b/%b/%h exp=0", bus.cli_read_valid, bus.cli_write_ack, bus.cli_read_data);
    end
    reset = 1'b0;
  endtask
  task automatic test_single_write;
    int extra;
    bus.cli_write_addr[0 +: AW] = 13'h0010;
    bus.cli_write_data[0 +: DW] = 16'h1234;
    bus.cli_write_req = 2'b01;
    tick;
    checks++;
    if ({bus.mem_write_req, bus.mem_read_req} !== 2'b10) begin
      failures++;
      $display("FAIL wr_req got=%b exp=10", {bus.mem_write_req, bus.mem_read_req});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_data_out} !== {13'h0010, 16'h1234}) begin
      failures++;
      $display("FAIL wr_addr_data got=%h/%h exp=0010/1234", bus.mem_addr, bus.mem_data_out);
    end
    bus.mem_write_ack = 1'b1;
    tick;
    bus.mem_write_ack = 1'b0;
    checks++;
    if ({bus.cli_write_ack, bus.mem_write_req} !== 3'b010) begin
      failures++;
      $display("FAIL wr_ack got=%b/%b exp=01/0", bus.cli_write_ack, bus.mem_write_req);
    end
    bus.cli_write_req = 2'b00;
    tick;
    checks++;
    if (bus.cli_write_ack !== 2'b00) begin
      failures++;
      $display("FAIL wr_ack_pulse got=%b exp=00", bus.cli_write_ack);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_write_req) extra++;
      tick;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL wr_no_repeat got=%0d exp=0", extra);
    end
  endtask
  task automatic test_single_read;
    bus.cli_read_addr[AW +: AW] = 13'h1FFF;
    bus.cli_read_req = 2'b10;
    tick;
    checks++;
    if ({bus.mem_write_req, bus.mem_read_req, bus.mem_addr} !== {2'b01, 13'h1FFF}) begin
      failures++;
      $display("FAIL rd_req got=%b%b/%h exp=01/1fff", bus.mem_write_req, bus.mem_read_req, bus.mem_addr);
    end
    tick;
    tick;
    checks++;
    if ({bus.mem_read_req, bus.cli_read_valid} !== 3'b100) begin
      failures++;
      $display("FAIL rd_hold got=%b/%b exp=1/00", bus.mem_read_req, bus.cli_read_valid);
    end
    bus.mem_data_in = 16'hBEEF;
    bus.mem_read_valid = 1'b1;
    tick;
    bus.mem_read_valid = 1'b0;
    bus.mem_data_in = 16'h0000;
    checks++;
    if ({bus.cli_read_valid, bus.cli_read_data, bus.mem_read_req} !== {2'b10, 16'hBEEF, 1'b0}) begin
      failures++;
      $display("FAIL rd_valid got=%b/%h/%b exp=10/beef/0", bus.cli_read_valid, bus.cli_read_data, bus.mem_read_req);
    end
    bus.cli_read_req = 2'b00;
    tick;
    checks++;
    if (bus.cli_read_valid !== 2'b00) begin
      failures++;
      $display("FAIL rd_valid_pulse got=%b exp=00", bus.cli_read_valid);
    end
  endtask
  task automatic test_round_robin;
    int acks0;
    int acks1;
    int n;
    int exp_c;
    acks0 = 0;
    acks1 = 0;
    bus.cli_write_addr = {13'h0B00, 13'h0A00};
    bus.cli_write_data = {16'hB1B1, 16'hA0A0};
    bus.cli_write_req = 2'b11;
    for (int t = 0; t < 8; t++) begin
      exp_c = t % 2;
      n = 0;
      do begin
        tick;
        n++;
      end while (!bus.mem_write_req && n < 6);
      checks++;
      if (n !== 1) begin
        failures++;
        $display("FAIL rr_gap t=%0d got=%0d exp=1", t, n);
      end
      checks++;
      if ({bus.mem_addr, bus.mem_data_out} !== (exp_c == 1 ? {13'h0B00, 16'hB1B1} : {13'h0A00, 16'hA0A0})) begin
        failures++;
        $display("FAIL rr_grant t=%0d got=%h/%h exp_client=%0d", t, bus.mem_addr, bus.mem_data_out, exp_c);
      end
      bus.mem_write_ack = 1'b1;
      tick;
      bus.mem_write_ack = 1'b0;
      if (bus.cli_write_ack[0]) acks0++;
      if (bus.cli_write_ack[1]) acks1++;
    end
    bus.cli_write_req = 2'b00;
    tick;
    checks++;
    if (acks0 !== 4 || acks1 !== 4) begin
      failures++;
      $display("FAIL rr_fair got=%0d/%0d exp=4/4", acks0, acks1);
    end
  endtask
  task automatic test_read_write_same;
    bus.cli_read_addr[0 +: AW] = 13'h0100;
    bus.cli_write_addr[0 +: AW] = 13'h0200;
    bus.cli_write_data[0 +: DW] = 16'h5555;
    bus.cli_read_req = 2'b01;
    bus.cli_write_req = 2'b01;
    tick;
    checks++;
    if ({bus.mem_write_req, bus.mem_read_req, bus.mem_addr} !== {2'b10, 13'h0200}) begin
      failures++;
      $display("FAIL rw_write_first got=%b%b/%h exp=10/0200", bus.mem_write_req, bus.mem_read_req, bus.mem_addr);
    end
    bus.mem_write_ack = 1'b1;
    tick;
    bus.mem_write_ack = 1'b0;
    checks++;
    if ({bus.cli_write_ack, bus.cli_read_valid} !== 4'b0100) begin
      failures++;
      $display("FAIL rw_ack got=%b/%b exp=01/00", bus.cli_write_ack, bus.cli_read_valid);
    end
    bus.cli_write_req = 2'b00;
    tick;
    checks++;
    if (bus.mem_read_req !== 1'b0) begin
      failures++;
      $display("FAIL rw_holdoff got=%b exp=0", bus.mem_read_req);
    end
    tick;
    checks++;
    if ({bus.mem_read_req, bus.mem_addr} !== {1'b1, 13'h0100}) begin
      failures++;
      $display("FAIL rw_read_next got=%b/%h exp=1/0100", bus.mem_read_req, bus.mem_addr);
    end
    bus.mem_data_in = 16'h7777;
    bus.mem_read_valid = 1'b1;
    tick;
    bus.mem_read_valid = 1'b0;
    checks++;
    if ({bus.cli_read_valid, bus.cli_read_data} !== {2'b01, 16'h7777}) begin
      failures++;
      $display("FAIL rw_read_valid got=%b/%h exp=01/7777", bus.cli_read_valid, bus.cli_read_data);
    end
    bus.cli_read_req = 2'b00;
    tick;
  endtask
  task automatic test_timeout;
    int n;
    bus.cli_read_addr[0 +: AW] = 13'h0042;
    bus.mem_data_in = 16'h9999;
    bus.cli_read_req = 2'b01;
    tick;
    checks++;
    if (bus.mem_read_req !== 1'b1) begin
      failures++;
      $display("FAIL to_req got=%b exp=1", bus.mem_read_req);
    end
    n = 0;
    do begin
      bus.mem_write_ack = (n == 3);
      tick;
      n++;
    end while (!bus.timeout_err && bus.cli_read_valid == 2'b00 && n < 300);
    bus.mem_write_ack = 1'b0;
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL to_cycles got=%0d exp=256", n);
    end
    checks++;
    if ({bus.timeout_err, bus.cli_read_valid, bus.cli_read_data, bus.mem_read_req} !== {1'b1, 2'b01, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL to_abort got=%b/%b/%h/%b exp=1/01/0000/0", bus.timeout_err, bus.cli_read_valid, bus.cli_read_data, bus.mem_read_req);
    end
    bus.cli_read_req = 2'b00;
    bus.mem_data_in = 16'h0000;
    tick;
    checks++;
    if ({bus.timeout_err, bus.cli_read_valid} !== 3'b000) begin
      failures++;
      $display("FAIL to_pulse got=%b/%b exp=0/00", bus.timeout_err, bus.cli_read_valid);
    end
  endtask
  task automatic test_stray_idle;
    bus.mem_data_in = 16'h1111;
    bus.mem_read_valid = 1'b1;
    bus.mem_write_ack = 1'b1;
    tick;
    bus.mem_read_valid = 1'b0;
    bus.mem_write_ack = 1'b0;
    bus.mem_data_in = 16'h0000;
    checks++;
    if ({bus.cli_read_valid, bus.cli_write_ack, bus.timeout_err, bus.cli_read_data} !== '0) begin
      failures++;
      $display("FAIL stray_idle got=%b/%b/%b/%h exp=0", bus.cli_read_valid, bus.cli_write_ack, bus.timeout_err, bus.cli_read_data);
    end
    tick;
  endtask
  task automatic test_reset_mid;
    int seen;
    bus.cli_read_addr[0 +: AW] = 13'h0033;
    bus.cli_read_req = 2'b01;
    tick;
    checks++;
    if (bus.mem_read_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_req got=%b exp=1", bus.mem_read_req);
    end
    reset = 1'b1;
    bus.mem_data_in = 16'hCAFE;
    bus.mem_read_valid = 1'b1;
    tick;
    checks++;
    if ({bus.mem_read_req, bus.mem_write_req, bus.mem_addr, bus.mem_data_out, bus.cli_read_valid, bus.cli_write_ack, bus.cli_read_data, bus.timeout_err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outs got=%b%b/%h/%h/%b/%b/%h/%b exp=0", bus.mem_read_req, bus.mem_write_req, bus.mem_addr, bus.mem_data_out, bus.cli_read_valid, bus.cli_write_ack, bus.cli_read_data, bus.timeout_err);
    end
    reset = 1'b0;
    bus.cli_read_req = 2'b00;
    seen = 0;
    tick;
    if (bus.cli_read_valid != 2'b00) seen++;
    bus.mem_read_valid = 1'b0;
    bus.mem_data_in = 16'h0000;
    bus.cli_write_addr[AW +: AW] = 13'h0777;
    bus.cli_write_data[DW +: DW] = 16'h0BAD;
    bus.cli_write_req = 2'b10;
    tick;
    if (bus.cli_read_valid != 2'b00) seen++;
    checks++;
    if ({bus.mem_write_req, bus.mem_read_req, bus.mem_addr, bus.mem_data_out} !== {2'b10, 13'h0777, 16'h0BAD}) begin
      failures++;
      $display("FAIL rst_fresh_grant got=%b%b/%h/%h exp=10/0777/0bad", bus.mem_write_req, bus.mem_read_req, bus.mem_addr, bus.mem_data_out);
    end
    bus.mem_write_ack = 1'b1;
    tick;
    bus.mem_write_ack = 1'b0;
    if (bus.cli_read_valid != 2'b00) seen++;
    checks++;
    if (bus.cli_write_ack !== 2'b10) begin
      failures++;
      $display("FAIL rst_fresh_ack got=%b exp=10", bus.cli_write_ack);
    end
    bus.cli_write_req = 2'b00;
    tick;
    if (bus.cli_read_valid != 2'b00) seen++;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_no_valid got=%0d exp=0", seen);
    end
  endtask
  initial begin
    bus.cli_read_req = '0;
    bus.cli_write_req = '0;
    bus.cli_read_addr = '0;
    bus.cli_write_addr = '0;
    bus.cli_write_data = '0;
    bus.mem_data_in = '0;
    bus.mem_read_valid = 1'b0;
    bus.mem_write_ack = 1'b0;
    test_reset;
    test_single_write;
    test_single_read;
    test_round_robin;
    test_read_write_same;
    test_timeout;
    test_stray_idle;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
